// File: rtl/button_conditioner.sv
// Conditions the five Nexys4 push-buttons: 2-flop synchronizer, per-button debounce FSM,
// registered debounced level and one-cycle press strobe, with optional auto-repeat while held.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_RATE     = 15_000_000,
    parameter logic [4:0]  REPEAT_MASK     = 5'b01111
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_pulse
);

    localparam int unsigned REPEAT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RCNT_W = $clog2(REPEAT_MAX) + 1;

    localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } btnState_t;

    logic [4:0] syncMeta;
    logic [4:0] syncBtn;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncMeta <= '0;
            syncBtn  <= '0;
        end else begin
            syncMeta <= btn_raw;
            syncBtn  <= syncMeta;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btnState_t         state;
        logic [DCNT_W-1:0] dcnt;
        logic [RCNT_W-1:0] rcnt;
        logic              repeating;
        logic              levelQ;
        logic              pulseQ;
        logic [RCNT_W-1:0] repeatLast;

        // The first repeat waits REPEAT_DELAY; once repeating, the shorter REPEAT_RATE applies.
        assign repeatLast   = repeating ? RATE_LAST : DELAY_LAST;
        assign btn_level[i] = levelQ;
        assign btn_pulse[i] = pulseQ;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state     <= IDLE;
                dcnt      <= '0;
                rcnt      <= '0;
                repeating <= 1'b0;
                levelQ    <= 1'b0;
                pulseQ    <= 1'b0;
            end else begin
                pulseQ <= 1'b0;
                case (state)
                    IDLE: begin
                        levelQ <= 1'b0;
                        dcnt   <= '0;
                        if (syncBtn[i]) state <= DB_PRESS;
                    end
                    DB_PRESS: begin
                        if (!syncBtn[i]) begin
                            state <= IDLE;
                            dcnt  <= '0;
                        end else if (dcnt == DCNT_LAST) begin
                            state     <= HELD;
                            dcnt      <= '0;
                            rcnt      <= '0;
                            repeating <= 1'b0;
                            levelQ    <= 1'b1;
                            pulseQ    <= 1'b1;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!syncBtn[i]) begin
                            state <= DB_RELEASE;
                            dcnt  <= '0;
                        end else if (REPEAT_MASK[i]) begin
                            if (rcnt == repeatLast) begin
                                rcnt      <= '0;
                                repeating <= 1'b1;
                                pulseQ    <= 1'b1;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                    end
                    DB_RELEASE: begin
                        // rcnt is left untouched here so a bounced release only delays the cadence.
                        if (syncBtn[i]) begin
                            state <= HELD;
                            dcnt  <= '0;
                        end else if (dcnt == DCNT_LAST) begin
                            state     <= IDLE;
                            dcnt      <= '0;
                            rcnt      <= '0;
                            repeating <= 1'b0;
                            levelQ    <= 1'b0;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed stimulus for button_conditioner, compared every cycle against a
// run-length / hold-tick reference model of the debounce and auto-repeat rules.
module tb_button_conditioner;

    localparam int         DB   = 4;
    localparam int         RD   = 10;
    localparam int         RR   = 3;
    localparam logic [4:0] MASK = 5'b01111;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    int checksRun    = 0;
    int checksPassed = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksRun++;
        if (observed === expected) checksPassed++;
        else $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, observed, expected, $time);
    endtask

    // Reference model: sync output is the raw input two edges old; a level flips after DB+1
    // consecutive samples disagreeing with it; repeat pulses fall on settled-hold tick counts.
    logic [4:0] rawHist [2];
    logic [4:0] mLevel;
    logic [4:0] mPulse;
    int         mRun   [5];
    int         mTicks [5];

    int cyc;
    int pulseCount [5];
    int firstPulse [5];

    task automatic modelReset();
        rawHist[0] = '0;
        rawHist[1] = '0;
        mLevel     = '0;
        mPulse     = '0;
        for (int b = 0; b < 5; b++) begin
            mRun[b]   = 0;
            mTicks[b] = 0;
        end
    endtask

    task automatic modelEdge(input logic [4:0] raw);
        logic [4:0] seen;
        logic       settled;
        seen       = rawHist[1];
        rawHist[1] = rawHist[0];
        rawHist[0] = raw;
        mPulse     = '0;
        for (int b = 0; b < 5; b++) begin
            if (seen[b] != mLevel[b]) begin
                mRun[b]++;
                if (mRun[b] == DB + 1) begin
                    mRun[b]   = 0;
                    mLevel[b] = seen[b];
                    mTicks[b] = 0;
                    if (seen[b]) mPulse[b] = 1'b1;
                end
            end else begin
                settled = (mRun[b] == 0);
                mRun[b] = 0;
                if (mLevel[b] && settled && MASK[b]) begin
                    mTicks[b]++;
                    if (mTicks[b] == RD || (mTicks[b] > RD && (mTicks[b] - RD) % RR == 0))
                        mPulse[b] = 1'b1;
                end
            end
        end
    endtask

    task automatic clearStats();
        cyc = -1;
        for (int b = 0; b < 5; b++) begin
            pulseCount[b] = 0;
            firstPulse[b] = -1;
        end
    endtask

    // Drive one cycle of raw input, step the model on the same edge, compare 1 time unit later.
    task automatic tick(input logic [4:0] raw);
        btn_raw = raw;
        @(posedge clk);
        modelEdge(raw);
        #1;
        cyc++;
        for (int b = 0; b < 5; b++) begin
            if (btn_pulse[b] === 1'b1) begin
                pulseCount[b]++;
                if (firstPulse[b] < 0) firstPulse[b] = cyc;
            end
        end
        check("level", 32'(btn_level), 32'(mLevel));
        check("pulse", 32'(btn_pulse), 32'(mPulse));
    endtask

    task automatic hold(input logic [4:0] raw, input int n);
        for (int c = 0; c < n; c++) tick(raw);
    endtask

    task automatic asyncReset(input logic [4:0] rawHold);
        btn_raw = rawHold;
        reset_n = 1'b0;
        #2;
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_pulse", 32'(btn_pulse), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    int         holdLeft [5];
    logic [4:0] cur;

    initial begin
        modelReset();
        clearStats();
        #1;
        asyncReset(5'b00000);
        hold(5'b00000, 4);

        // Clean press on bit 3.
        clearStats();
        hold(5'b01000, 8);
        hold(5'b00000, 12);
        check("clean_first", 32'(firstPulse[3]), 32'd6);
        check("clean_count", 32'(pulseCount[3]), 32'd1);

        // Bouncing press on bit 4, then a stable hold.
        clearStats();
        for (int r = 0; r < 2; r++) begin
            hold(5'b10000, 3);
            hold(5'b00000, 3);
        end
        check("bounce_quiet", 32'(pulseCount[4]), 32'd0);
        clearStats();
        hold(5'b10000, 12);
        hold(5'b00000, 12);
        check("bounce_first", 32'(firstPulse[4]), 32'd6);
        check("bounce_count", 32'(pulseCount[4]), 32'd1);

        // Auto-repeat on bit 0 versus the non-repeating bit 4.
        clearStats();
        hold(5'b10001, 30);
        hold(5'b00000, 15);
        check("rep_first", 32'(firstPulse[0]), 32'd6);
        check("rep_count", 32'(pulseCount[0]), 32'd7);
        check("norep_count", 32'(pulseCount[4]), 32'd1);

        // Release glitches on bit 1: a short drop keeps the level, a long drop releases it.
        clearStats();
        hold(5'b00010, 20);
        hold(5'b00000, 2);
        hold(5'b00010, 20);
        check("glitch_level", 32'(btn_level[1]), 32'd1);
        hold(5'b00000, 6);
        hold(5'b00010, 1);
        hold(5'b00000, 12);
        check("drop_level", 32'(btn_level[1]), 32'd0);

        // Simultaneous presses on bits 2 and 1.
        clearStats();
        hold(5'b00110, 8);
        hold(5'b00000, 12);
        check("simul_b2", 32'(firstPulse[2]), 32'd6);
        check("simul_b1", 32'(firstPulse[1]), 32'd6);

        // Reset while held, button still pressed through release of reset.
        hold(5'b00001, 12);
        asyncReset(5'b00001);
        clearStats();
        hold(5'b00001, 10);
        check("rst_fresh", 32'(firstPulse[0]), 32'd6);
        hold(5'b00000, 12);

        // Randomized per-bit hold lengths with occasional resets.
        cur = '0;
        for (int b = 0; b < 5; b++) holdLeft[b] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 5; b++) begin
                if (holdLeft[b] == 0) begin
                    cur[b]      = 1'($urandom_range(0, 1));
                    holdLeft[b] = int'($urandom_range(1, 30));
                end
                holdLeft[b]--;
            end
            if ($urandom_range(0, 599) == 0) asyncReset(cur);
            tick(cur);
        end

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
